push_btn_conditioner: RTL and testbench

// Input-side front end for the pipelined RV32I core's io_push_i port.

---
 rtl/push_btn_if.sv | 22 ++
 rtl/push_btn_conditioner.sv | 75 +++++++
 tb/tb_push_btn_conditioner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/push_btn_if.sv
// Board push-button bundle: raw pads and clear-register store in, the word
// presented to the core's io_push_i read mux, press pulses and irq out.
interface push_btn_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw_i;
    logic             clr_we_i;
    logic [N_BTN-1:0] clr_wdata_i;
    logic [31:0]      io_push_o;
    logic [N_BTN-1:0] press_pulse_o;
    logic             irq_o;

    modport master (
        output btn_raw_i, clr_we_i, clr_wdata_i,
        input  io_push_o, press_pulse_o, irq_o
    );

    modport slave (
        input  btn_raw_i, clr_we_i, clr_wdata_i,
        output io_push_o, press_pulse_o, irq_o
    );
endinterface

// File: rtl/push_btn_conditioner.sv
// Push-button front end: polarity normalise, 2-FF sync, per-bit debounce,
// press-pulse detection and write-1-to-clear sticky press events.
module push_btn_conditioner #(
    parameter int N_BTN          = 4,
    parameter int DEB_CYCLES     = 500000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    push_btn_if.slave  btn_bus
);
    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] btn_norm;
    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] event_q, event_d;
    logic [N_BTN-1:0] clr_mask;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [31:0]      io_push;

    // Pressed reads as 1 from here on, whatever the pad polarity.
    assign btn_norm = btn_bus.btn_raw_i ^ {N_BTN{BTN_ACTIVE_LOW}};

    // The counter is cleared on acceptance, so it never runs past CNT_LAST.
    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
            assign cnt_d[gi] = (sync2_q[gi] == level_q[gi]) ? '0 :
                               (cnt_q[gi] == CNT_LAST)      ? '0 :
                                                              cnt_q[gi] + 1'b1;
            assign level_d[gi] = (sync2_q[gi] != level_q[gi] && cnt_q[gi] == CNT_LAST)
                               ? sync2_q[gi] : level_q[gi];
        end
    endgenerate

    assign pulse_d  = level_d & ~level_q;
    assign clr_mask = {N_BTN{btn_bus.clr_we_i}} & btn_bus.clr_wdata_i;
    // OR-ing the pulse in after the clear makes a same-cycle set win.
    assign event_d  = (event_q & ~clr_mask) | pulse_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            event_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_norm;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            event_q <= event_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        io_push               = '0;
        io_push[N_BTN-1:0]    = level_q;
        io_push[16 +: N_BTN]  = event_q;
    end

    assign btn_bus.io_push_o     = io_push;
    assign btn_bus.press_pulse_o = pulse_q;
    assign btn_bus.irq_o         = |event_q;
endmodule

// File: tb/tb_push_btn_conditioner.sv
// Directed bench for push_btn_conditioner with DEB_CYCLES=8, N_BTN=4, active-low pads.
module tb_push_btn_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt;

    always #5 clk = ~clk;

    push_btn_if #(.N_BTN(4)) bus ();

    push_btn_conditioner #(
        .N_BTN(4),
        .DEB_CYCLES(8),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_bus (bus.slave)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.press_pulse_o != 4'h0) pulse_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.btn_raw_i   = 4'hF;
        bus.clr_we_i    = 1'b0;
        bus.clr_wdata_i = 4'h0;

        // 1 reset
        tick(3);
        check("rst_io_push", bus.io_push_o, 32'h0);
        check("rst_pulse", {28'h0, bus.press_pulse_o}, 32'h0);
        check("rst_irq", {31'h0, bus.irq_o}, 32'h0);
        rst = 1'b0;
        tick(4);
        check("post_rst_io_push", bus.io_push_o, 32'h0);

        // 2 clean press of bit0: level appears 10 edges after the raw edge
        bus.btn_raw_i = 4'hE;
        pulse_cnt = 0;
        tick(9);
        check("press_edge9", bus.io_push_o, 32'h0);
        tick(1);
        check("press_edge10", bus.io_push_o, 32'h0000_0001);
        check("press_pulse", {28'h0, bus.press_pulse_o}, 32'h1);
        tick(1);
        check("press_event", bus.io_push_o, 32'h0001_0001);
        check("press_irq", {31'h0, bus.irq_o}, 32'h1);
        check("press_pulse_gone", {28'h0, bus.press_pulse_o}, 32'h0);
        tick(9);
        check("press_pulse_count", pulse_cnt, 32'd1);
        check("press_hold", bus.io_push_o, 32'h0001_0001);

        // 3 bounce on bit1, runs of 3 never reach the debounce threshold
        pulse_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            bus.btn_raw_i[1] = ~bus.btn_raw_i[1];
            tick(3);
        end
        bus.btn_raw_i = 4'hE;
        tick(12);
        check("bounce_io_push", bus.io_push_o, 32'h0001_0001);
        check("bounce_pulse_count", pulse_cnt, 32'd0);

        // 4 clear: strobe low is ignored, then W1C on bit0
        bus.clr_wdata_i = 4'h1;
        tick(1);
        check("clr_we_low_ignored", bus.io_push_o, 32'h0001_0001);
        bus.clr_we_i = 1'b1;
        tick(1);
        bus.clr_we_i    = 1'b0;
        bus.clr_wdata_i = 4'h0;
        check("clr_bit0", bus.io_push_o, 32'h0000_0001);
        check("clr_irq", {31'h0, bus.irq_o}, 32'h0);

        // press bit1 with a same-cycle clear of bit1: set wins
        bus.btn_raw_i = 4'hC;
        tick(10);
        check("bit1_pulse", {28'h0, bus.press_pulse_o}, 32'h2);
        bus.clr_we_i    = 1'b1;
        bus.clr_wdata_i = 4'h2;
        tick(1);
        bus.clr_we_i    = 1'b0;
        bus.clr_wdata_i = 4'h0;
        check("set_wins", bus.io_push_o, 32'h0002_0003);
        tick(1);
        check("set_wins_hold", bus.io_push_o, 32'h0002_0003);

        // 5 release bit0: level drops after 10 edges, no pulse, events unchanged
        pulse_cnt = 0;
        bus.btn_raw_i = 4'hD;
        tick(9);
        check("release_edge9", bus.io_push_o, 32'h0002_0003);
        tick(1);
        check("release_edge10", bus.io_push_o, 32'h0002_0002);
        tick(2);
        check("release_pulse_count", pulse_cnt, 32'd0);

        // 6 reset mid-debounce of bit2, bits 1 and 2 held through reset
        bus.btn_raw_i = 4'h9;
        tick(6);
        rst = 1'b1;
        #1;
        check("midrst_io_push", bus.io_push_o, 32'h0);
        check("midrst_irq", {31'h0, bus.irq_o}, 32'h0);
        tick(3);
        check("midrst_held", bus.io_push_o, 32'h0);
        check("midrst_pulse", {28'h0, bus.press_pulse_o}, 32'h0);
        rst = 1'b0;
        pulse_cnt = 0;
        tick(9);
        check("rerelease_edge9", bus.io_push_o, 32'h0);
        tick(1);
        check("rerelease_edge10", bus.io_push_o, 32'h0000_0006);
        check("rerelease_pulse", {28'h0, bus.press_pulse_o}, 32'h6);
        tick(1);
        check("rerelease_event", bus.io_push_o, 32'h0006_0006);
        check("rerelease_irq", {31'h0, bus.irq_o}, 32'h1);
        tick(3);
        check("rerelease_pulse_count", pulse_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
